// File: rtl/mrv1_itag_queue.sv
// mrv1_itag_queue: per-thread in-order itag allocator and destination-register queue.
// Latency: a dispatch or retire is visible on iq_rd_*, occ_o and retire_itag_o one cycle later.
// Backpressure: disp_rdy_o drops when the selected thread holds iqueue_size_lp entries.
//
// Ports:
//   clk_i, rst_ni      clock and synchronous active-low reset
//   disp_*             dispatch request: thread, dest-reg valid/address; rdy and allocated itag back
//   tw_flush_i         per-thread flush; empties that thread's queue
//   retire_cnt_i       per-thread count of entries retired this cycle
//   retire_rdy_o       per-thread non-empty flag; retire_itag_o is the per-thread head itag
//   iq_rd_vld_o/addr_o per-entry destination-register view; unoccupied entries read 0
//   occ_o              per-thread occupancy
module mrv1_itag_queue #(
  parameter int NUM_TW_P        = 8,
  parameter int ITAG_WIDTH_P    = 4,
  parameter int rf_addr_width_p = 5,
  localparam int twid_width_lp  = $clog2(NUM_TW_P),
  localparam int iqueue_size_lp = 1 << ITAG_WIDTH_P
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_ni,
  input  logic                                                 disp_vld_i,
  input  logic [twid_width_lp-1:0]                             disp_twid_i,
  input  logic                                                 disp_rd_vld_i,
  input  logic [rf_addr_width_p-1:0]                           disp_rd_addr_i,
  output logic                                                 disp_rdy_o,
  output logic [ITAG_WIDTH_P-1:0]                              disp_itag_o,
  input  logic [NUM_TW_P-1:0]                                  tw_flush_i,
  input  logic [NUM_TW_P*ITAG_WIDTH_P-1:0]                     retire_cnt_i,
  output logic [NUM_TW_P-1:0]                                  retire_rdy_o,
  output logic [NUM_TW_P*ITAG_WIDTH_P-1:0]                     retire_itag_o,
  output logic [NUM_TW_P*iqueue_size_lp-1:0]                   iq_rd_vld_o,
  output logic [NUM_TW_P*iqueue_size_lp*rf_addr_width_p-1:0]   iq_rd_addr_o,
  output logic [NUM_TW_P*(ITAG_WIDTH_P+1)-1:0]                 occ_o
);

  localparam logic [ITAG_WIDTH_P:0] full_cnt_lp = (ITAG_WIDTH_P+1)'(iqueue_size_lp);

  logic [ITAG_WIDTH_P-1:0]    head_q    [NUM_TW_P];
  logic [ITAG_WIDTH_P-1:0]    tail_q    [NUM_TW_P];
  logic [ITAG_WIDTH_P:0]      cnt_q     [NUM_TW_P];
  logic [iqueue_size_lp-1:0]  rd_vld_q  [NUM_TW_P];
  logic [rf_addr_width_p-1:0] rd_addr_q [NUM_TW_P][iqueue_size_lp];

  logic [NUM_TW_P-1:0]        acc;
  logic [ITAG_WIDTH_P:0]      ret_r     [NUM_TW_P];
  logic [iqueue_size_lp-1:0]  ret_clr   [NUM_TW_P];

  // Readiness looks only at registered occupancy, so a retire in the same
  // cycle never opens a slot for a dispatch.
  assign disp_rdy_o  = (cnt_q[disp_twid_i] != full_cnt_lp);
  assign disp_itag_o = tail_q[disp_twid_i];

  always_comb begin
    for (int t = 0; t < NUM_TW_P; t++) begin
      acc[t]     = 1'b0;
      ret_r[t]   = '0;
      ret_clr[t] = '0;
    end
    for (int t = 0; t < NUM_TW_P; t++) begin
      acc[t] = disp_vld_i & disp_rdy_o & ~tw_flush_i[t] &
               (disp_twid_i == twid_width_lp'(t));
      // Clamp the retire count to what the thread actually holds.
      if ({1'b0, retire_cnt_i[t*ITAG_WIDTH_P +: ITAG_WIDTH_P]} > cnt_q[t])
        ret_r[t] = cnt_q[t];
      else
        ret_r[t] = {1'b0, retire_cnt_i[t*ITAG_WIDTH_P +: ITAG_WIDTH_P]};
      // Entry i is retired when its distance from head (mod depth) is below r.
      for (int i = 0; i < iqueue_size_lp; i++)
        ret_clr[t][i] = ({1'b0, ITAG_WIDTH_P'(i) - head_q[t]} < ret_r[t]);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int t = 0; t < NUM_TW_P; t++) begin
      if (!rst_ni || tw_flush_i[t]) begin
        head_q[t]   <= '0;
        tail_q[t]   <= '0;
        cnt_q[t]    <= '0;
        rd_vld_q[t] <= '0;
        for (int i = 0; i < iqueue_size_lp; i++)
          rd_addr_q[t][i] <= '0;
      end else begin
        head_q[t] <= head_q[t] + ITAG_WIDTH_P'(ret_r[t]);
        tail_q[t] <= tail_q[t] + ITAG_WIDTH_P'(acc[t]);
        cnt_q[t]  <= cnt_q[t] + (ITAG_WIDTH_P+1)'(acc[t]) - ret_r[t];
        // The tail slot is never occupied on accept, so the retire clear and
        // the dispatch write cannot target the same entry.
        for (int i = 0; i < iqueue_size_lp; i++) begin
          if (ret_clr[t][i]) begin
            rd_vld_q[t][i]  <= 1'b0;
            rd_addr_q[t][i] <= '0;
          end else if (acc[t] && (tail_q[t] == ITAG_WIDTH_P'(i))) begin
            rd_vld_q[t][i]  <= disp_rd_vld_i;
            rd_addr_q[t][i] <= disp_rd_vld_i ? disp_rd_addr_i : '0;
          end
        end
      end
    end
  end

  for (genvar t = 0; t < NUM_TW_P; t++) begin : g_out
    assign retire_rdy_o[t]                                   = (cnt_q[t] != '0);
    assign retire_itag_o[t*ITAG_WIDTH_P +: ITAG_WIDTH_P]     = head_q[t];
    assign iq_rd_vld_o[t*iqueue_size_lp +: iqueue_size_lp]   = rd_vld_q[t];
    assign occ_o[t*(ITAG_WIDTH_P+1) +: ITAG_WIDTH_P+1]       = cnt_q[t];
    for (genvar i = 0; i < iqueue_size_lp; i++) begin : g_ent
      assign iq_rd_addr_o[(t*iqueue_size_lp+i)*rf_addr_width_p +: rf_addr_width_p] = rd_addr_q[t][i];
    end
  end

endmodule

// File: tb/tb_mrv1_itag_queue.sv
// tb_mrv1_itag_queue: directed self-checking bench for mrv1_itag_queue.
// Latency: registered outputs checked #1 after the clock edge following stimulus.
// Backpressure: exercises full-thread rejection and wrap-around reuse.
module tb_mrv1_itag_queue;

  localparam int NT = 8;
  localparam int IW = 4;
  localparam int AW = 5;
  localparam int D  = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              disp_vld_i;
  logic [2:0]        disp_twid_i;
  logic              disp_rd_vld_i;
  logic [AW-1:0]     disp_rd_addr_i;
  logic              disp_rdy_o;
  logic [IW-1:0]     disp_itag_o;
  logic [NT-1:0]     tw_flush_i;
  logic [NT*IW-1:0]  retire_cnt_i;
  logic [NT-1:0]     retire_rdy_o;
  logic [NT*IW-1:0]  retire_itag_o;
  logic [NT*D-1:0]   iq_rd_vld_o;
  logic [NT*D*AW-1:0] iq_rd_addr_o;
  logic [NT*(IW+1)-1:0] occ_o;

  int checks = 0;
  int errors = 0;

  mrv1_itag_queue dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .disp_vld_i     (disp_vld_i),
    .disp_twid_i    (disp_twid_i),
    .disp_rd_vld_i  (disp_rd_vld_i),
    .disp_rd_addr_i (disp_rd_addr_i),
    .disp_rdy_o     (disp_rdy_o),
    .disp_itag_o    (disp_itag_o),
    .tw_flush_i     (tw_flush_i),
    .retire_cnt_i   (retire_cnt_i),
    .retire_rdy_o   (retire_rdy_o),
    .retire_itag_o  (retire_itag_o),
    .iq_rd_vld_o    (iq_rd_vld_o),
    .iq_rd_addr_o   (iq_rd_addr_o),
    .occ_o          (occ_o)
  );

  always #5 clk_i = ~clk_i;

  // Retiring more than a thread holds is illegal stimulus.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      for (int t = 0; t < NT; t++)
        assert ({1'b0, retire_cnt_i[t*IW +: IW]} <= occ_o[t*(IW+1) +: IW+1])
          else $error("illegal retire count on thread %0d", t);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW:0] occ(input int t);
    return occ_o[t*(IW+1) +: IW+1];
  endfunction
  function automatic logic [IW-1:0] hitag(input int t);
    return retire_itag_o[t*IW +: IW];
  endfunction
  function automatic logic ev(input int t, input int i);
    return iq_rd_vld_o[t*D + i];
  endfunction
  function automatic logic [AW-1:0] ea(input int t, input int i);
    return iq_rd_addr_o[(t*D+i)*AW +: AW];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ret(input int t, input int n);
    retire_cnt_i = '0;
    retire_cnt_i[t*IW +: IW] = IW'(n);
  endtask

  task automatic disp(input int t, input logic rv, input int a);
    disp_vld_i     = 1'b1;
    disp_twid_i    = 3'(t);
    disp_rd_vld_i  = rv;
    disp_rd_addr_i = AW'(a);
  endtask

  initial begin
    rst_ni = 1'b0;
    tw_flush_i = '0;
    retire_cnt_i = '0;
    disp(3, 1'b1, 7);
    step();
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    disp_vld_i = 1'b0;
    disp_twid_i = 3'd0;
    #1;
    check("rst_occ",   occ_o, '0);
    check("rst_vld",   iq_rd_vld_o, '0);
    check("rst_addr",  iq_rd_addr_o, '0);
    check("rst_rrdy",  retire_rdy_o, '0);
    check("rst_ritag", retire_itag_o, '0);
    check("rst_drdy",  disp_rdy_o, 1);
    check("rst_ditag", disp_itag_o, 0);

    // Fill thread 3.
    for (int k = 0; k < D; k++) begin
      disp(3, 1'b1, k);
      #1;
      check($sformatf("fill_itag%0d", k), disp_itag_o, k);
      step();
    end
    disp_vld_i = 1'b0;
    #1;
    check("full_occ3",   occ(3), 16);
    check("full_vld3",   iq_rd_vld_o[3*D +: D], 16'hFFFF);
    check("full_addr7",  ea(3, 7), 7);
    check("full_rrdy3",  retire_rdy_o[3], 1);
    check("full_head3",  hitag(3), 0);
    check("full_rdy3",   disp_rdy_o, 0);
    disp_twid_i = 3'd2;
    #1;
    check("rdy_tw2",     disp_rdy_o, 1);

    // 17th request rejected.
    disp(3, 1'b1, 20);
    step();
    disp_vld_i = 1'b0;
    #1;
    check("rej17_occ",   occ(3), 16);
    check("rej17_addr0", ea(3, 0), 0);

    // Retire 5 at full with a simultaneous dispatch.
    disp(3, 1'b1, 21);
    set_ret(3, 5);
    #1;
    check("fullret_rdy", disp_rdy_o, 0);
    step();
    disp_vld_i = 1'b0;
    retire_cnt_i = '0;
    #1;
    check("ret5_head",   hitag(3), 5);
    check("ret5_occ",    occ(3), 11);
    check("ret5_vld",    iq_rd_vld_o[3*D +: 5], 5'h0);
    check("ret5_addr4",  ea(3, 4), 0);
    check("ret5_vld5",   ev(3, 5), 1);
    disp(3, 1'b1, 22);
    #1;
    check("wrap_itag",   disp_itag_o, 0);
    check("wrap_rdy",    disp_rdy_o, 1);
    step();
    disp_vld_i = 1'b0;
    #1;
    check("wrap_occ",    occ(3), 12);
    check("wrap_addr0",  ea(3, 0), 22);

    // Thread 1: head 14, tail 2, cnt 4.
    for (int k = 0; k < 14; k++) begin
      disp(1, 1'b1, k);
      step();
    end
    disp_vld_i = 1'b0;
    set_ret(1, 14);
    step();
    retire_cnt_i = '0;
    for (int k = 1; k <= 4; k++) begin
      disp(1, 1'b1, k);
      step();
    end
    disp_vld_i = 1'b0;
    #1;
    check("t1_head14",   hitag(1), 14);
    check("t1_occ4",     occ(1), 4);
    set_ret(1, 3);
    step();
    retire_cnt_i = '0;
    #1;
    check("t1_head1",    hitag(1), 1);
    check("t1_occ1",     occ(1), 1);
    check("t1_vld",      iq_rd_vld_o[1*D +: D], 16'h0002);
    check("t1_addr1",    ea(1, 1), 4);
    check("t1_addr14",   ea(1, 14), 0);

    // Dispatch without a destination register.
    disp(1, 1'b0, 9);
    #1;
    check("nord_itag",   disp_itag_o, 2);
    step();
    disp_vld_i = 1'b0;
    #1;
    check("nord_vld",    ev(1, 2), 0);
    check("nord_addr",   ea(1, 2), 0);
    check("nord_occ",    occ(1), 2);

    // Thread 5: 7 entries, then flush with same-cycle retire and dispatch.
    for (int k = 0; k < 7; k++) begin
      disp(5, 1'b1, k + 10);
      step();
    end
    disp_vld_i = 1'b0;
    #1;
    check("t5_occ7",     occ(5), 7);
    disp(5, 1'b1, 30);
    set_ret(5, 2);
    tw_flush_i = 8'h20;
    step();
    disp_vld_i = 1'b0;
    retire_cnt_i = '0;
    tw_flush_i = '0;
    disp_twid_i = 3'd5;
    #1;
    check("fl_occ5",     occ(5), 0);
    check("fl_head5",    hitag(5), 0);
    check("fl_tail5",    disp_itag_o, 0);
    check("fl_rrdy5",    retire_rdy_o[5], 0);
    check("fl_vld5",     iq_rd_vld_o[5*D +: D], 16'h0);
    check("fl_addr5",    iq_rd_addr_o[5*D*AW +: D*AW], '0);
    check("fl_occ3",     occ(3), 12);
    check("fl_head3",    hitag(3), 5);
    check("fl_vld3",     iq_rd_vld_o[3*D +: D], 16'hFFE1);
    check("fl_addr3_10", ea(3, 10), 10);
    check("fl_occ1",     occ(1), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
